// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types and constants for the execution trace buffer.
//   TRACE_XLEN   : width of pc / instruction / alu_result captured per entry
//   TRACE_CYC_W  : default cycle-stamp width used by trace_entry_t
//   DROP_W       : width of the saturating drop counter
//   trace_cpu_t  : {pc, instr, alu} processor-side payload
//   trace_entry_t: {cycle, pc, instr, alu} full entry, cycle in the MSBs
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam int unsigned TRACE_XLEN  = 32;
    localparam int unsigned TRACE_CYC_W = 32;
    localparam int unsigned DROP_W      = 16;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] instr;
        logic [TRACE_XLEN-1:0] alu;
    } trace_cpu_t;

    typedef struct packed {
        logic [TRACE_CYC_W-1:0] cycle;
        trace_cpu_t             cpu;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO with a registered head word.
//   clk, reset_n  : rising-edge clock, asynchronous active-low reset
//   clear         : synchronous flush
//   push/push_data: write request; accepted when not full, or when full and
//                   a pop happens in the same cycle
//   pop           : remove head (ignored when empty)
//   head_data     : registered head entry, meaningful while !empty
//   full/empty    : occupancy flags
//   level         : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] head_q,   head_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign level     = count_q;
    assign head_data = head_q;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            // Head register tracks the next oldest entry: either the stored
            // successor, or the incoming word when it becomes the only entry.
            if (do_pop && count_q > (AW+1)'(1)) begin
                head_d = mem_q[rd_ptr_q + AW'(1)];
            end else if (do_push && (empty || (do_pop && count_q == (AW+1)'(1)))) begin
                head_d = push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/exec_trace_buffer.sv
// -----------------------------------------------------------------------------
// exec_trace_buffer
// Captures one trace entry {cycle, pc, instr, alu} each time the processor PC
// changes, queues it in a FIFO and drains it over a valid/ready stream.
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   trace_en     : capture enable (cycle counter runs only while high)
//   clear        : synchronous clear of FIFO, cycle, drop count, stall state
//   pc_in, instr_in, alu_in : processor debug taps
//   out_valid/out_ready/out_data : entry stream, cycle stamp in the MSBs
//   level        : FIFO occupancy
//   drop_count   : saturating count of entries lost to a full FIFO
//   stall_flag   : sticky stuck-PC indicator
// Optional feature: define STALL_DETECT_EN to build the stall detector;
// otherwise stall_flag is tied low.
// -----------------------------------------------------------------------------
module exec_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CYC_W       = 32,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          trace_en,
    input  logic                          clear,
    input  logic [TRACE_XLEN-1:0]         pc_in,
    input  logic [TRACE_XLEN-1:0]         instr_in,
    input  logic [TRACE_XLEN-1:0]         alu_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3*TRACE_XLEN+CYC_W-1:0] out_data,
    output logic [$clog2(DEPTH):0]        level,
    output logic [DROP_W-1:0]             drop_count,
    output logic                          stall_flag
);

    localparam int unsigned WIDTH = 3*TRACE_XLEN + CYC_W;

    logic [CYC_W-1:0]      cycle_q,   cycle_d;
    logic                  first_q,   first_d;
    logic [TRACE_XLEN-1:0] last_pc_q, last_pc_d;
    logic [DROP_W-1:0]     drop_q,    drop_d;
    logic                  capture, pop, fifo_full, fifo_empty;
    trace_cpu_t            cpu;

    assign cpu       = '{pc: pc_in, instr: instr_in, alu: alu_in};
    assign capture   = trace_en && !clear && (first_q || pc_in != last_pc_q);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop_count = drop_q;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (capture),
        .push_data ({cycle_q, cpu}),
        .pop       (pop),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_comb begin
        cycle_d   = cycle_q;
        first_d   = first_q;
        last_pc_d = last_pc_q;
        drop_d    = drop_q;
        if (clear) begin
            cycle_d = '0;
            first_d = 1'b1;
            drop_d  = '0;
        end else begin
            if (trace_en) begin
                cycle_d = cycle_q + CYC_W'(1);
            end
            // Leaving the enabled state re-arms the detector so the first
            // enabled cycle afterwards always captures.
            if (!trace_en) begin
                first_d = 1'b1;
            end else if (capture) begin
                first_d   = 1'b0;
                last_pc_d = pc_in;
            end
            if (capture && fifo_full && !pop && drop_q != '1) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q   <= '0;
            first_q   <= 1'b1;
            last_pc_q <= '0;
            drop_q    <= '0;
        end else begin
            cycle_q   <= cycle_d;
            first_q   <= first_d;
            last_pc_q <= last_pc_d;
            drop_q    <= drop_d;
        end
    end

`ifdef STALL_DETECT_EN
    localparam int unsigned STALL_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT - 1);

    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               stall_flag_q, stall_flag_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        stall_flag_d = stall_flag_q;
        if (clear || !trace_en || capture) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
        if (clear) begin
            stall_flag_d = 1'b0;
        end else if (stall_cnt_d == STALL_MAX) begin
            stall_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            stall_flag_q <= 1'b0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            stall_flag_q <= stall_flag_d;
        end
    end

    assign stall_flag = stall_flag_q;
`else
    assign stall_flag = 1'b0;
`endif

endmodule

// File: tb/tb_exec_trace_buffer.sv
module tb_exec_trace_buffer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         trace_en;
    logic         clear;
    logic [31:0]  pc_in, instr_in, alu_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   level;
    logic [15:0]  drop_count;
    logic         stall_flag;

    int unsigned total  = 0;
    int unsigned passed = 0;

    exec_trace_buffer #(
        .DEPTH       (16),
        .CYC_W       (32),
        .STALL_LIMIT (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trace_en   (trace_en),
        .clear      (clear),
        .pc_in      (pc_in),
        .instr_in   (instr_in),
        .alu_in     (alu_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .drop_count (drop_count),
        .stall_flag (stall_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ent(input logic [31:0] cyc, input logic [31:0] pc);
        return {cyc, pc, pc ^ 32'hA5A5_0000, pc + 32'd1};
    endfunction

    task automatic set_pc(input logic [31:0] pc);
        pc_in    = pc;
        instr_in = pc ^ 32'hA5A5_0000;
        alu_in   = pc + 32'd1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset_n   = 1'b0;
        trace_en  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        set_pc(32'h0);
        #12;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data",  out_data, 128'h0);
        chk("rst_level", level, 5'd0);
        chk("rst_drop",  drop_count, 16'd0);
        chk("rst_stall", stall_flag, 1'b0);
        reset_n = 1'b1;
        step();

        // 1: four consecutive PCs streamed straight through
        trace_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_pc(32'(4*i));
            step();
            chk("t1_valid", out_valid, 1'b1);
            chk("t1_data",  out_data, ent(32'(i), 32'(4*i)));
            chk("t1_level", level, 5'd1);
        end
        chk("t1_drop", drop_count, 16'd0);

        // 2: PC held at 8 gives one entry (stamp 4)
        set_pc(32'h8);
        step();
        chk("t2_data", out_data, ent(32'd4, 32'h8));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_empty", out_valid, 1'b0);
        end
        chk("t2_level", level, 5'd0);

        // 3: 20 PCs into a stalled consumer; cycle is 9 at the first
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_pc(32'h1000 + 32'(4*i));
            step();
        end
        chk("t3_level", level, 5'd16);
        chk("t3_drop",  drop_count, 16'd4);
        chk("t3_head",  out_data, ent(32'd9, 32'h1000));

        // 4: full FIFO, pop and push together (stamp 29)
        out_ready = 1'b1;
        set_pc(32'h2000);
        step();
        chk("t4_level", level, 5'd16);
        chk("t4_drop",  drop_count, 16'd4);
        trace_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("t3_drain", out_data, ent(32'(9 + i), 32'h1000 + 32'(4*i)));
            step();
        end
        chk("t4_last", out_data, ent(32'd29, 32'h2000));
        step();
        chk("t4_empty", out_valid, 1'b0);
        chk("t4_level0", level, 5'd0);

        // 5: asynchronous reset mid-drain (cycle is 30 here)
        trace_en  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pc(32'h3000 + 32'(4*i));
            step();
        end
        chk("t5_head", out_data, ent(32'd30, 32'h3000));
        out_ready = 1'b1;
        step();
        chk("t5_level2", level, 5'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_level", level, 5'd0);
        chk("t5_drop",  drop_count, 16'd0);
        reset_n = 1'b1;
        set_pc(32'h4000);
        step();
        chk("t5_cap0", out_data, ent(32'd0, 32'h4000));
        chk("t5_lvl1", level, 5'd1);
        step();
        chk("t5_drained", out_valid, 1'b0);

        // clear: empties FIFO, restarts cycle, re-arms capture of same PC
        out_ready = 1'b0;
        set_pc(32'h5000);
        step();
        set_pc(32'h5004);
        step();
        chk("clr_pre", level, 5'd2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_level", level, 5'd0);
        chk("clr_valid", out_valid, 1'b0);
        step();
        chk("clr_cap", out_data, ent(32'd0, 32'h5004));
        chk("clr_lvl1", level, 5'd1);

        // 6: PC frozen at 0x5004
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
`ifdef STALL_DETECT_EN
            chk("t6_stall", stall_flag, (k >= 7) ? 1'b1 : 1'b0);
`else
            chk("t6_stall", stall_flag, 1'b0);
`endif
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t6_clear", stall_flag, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
